// File: rtl/ram_dp_param.sv
// Dual-port word RAM: read/write data port, read-only fetch port.
// Byte enables, registered outputs, range check and a clear engine.
module ram_dp_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ENABLE,
    input  logic                RW,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   DIN,
    input  logic [DATA_W/8-1:0] BE,
    output logic [DATA_W-1:0]   DOUT,
    output logic                DVALID,
    input  logic                F,
    input  logic [ADDR_W-1:0]   FADDR,
    output logic [DATA_W-1:0]   FETCH,
    output logic                FVALID,
    input  logic                CLEAR,
    output logic                BUSY,
    output logic                ERR
);

    localparam int NB = DATA_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;

    logic [DATA_W-1:0] mem [DEPTH];

    logic d_ok, f_ok;
    logic [AW-1:0] da, fa;
    logic acc, we, rd, fe, err_n;

    assign d_ok = {1'b0, ADDR} < LIM;
    assign f_ok = {1'b0, FADDR} < LIM;
    assign da = ADDR[AW-1:0];
    assign fa = FADDR[AW-1:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_CLEAR;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        unique case (state)
            S_CLEAR: begin
                if (cnt == LAST) begin
                    state_n = S_RUN;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (CLEAR) begin
                    state_n = S_CLEAR;
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = S_CLEAR;
                cnt_n = '0;
            end
        endcase
    end

    // A clear request outranks any data/fetch request in the same cycle
    always_comb begin
        BUSY = (state == S_CLEAR);
        acc = (state == S_RUN) && !CLEAR;
        rd = acc && ENABLE && RW;
        we = acc && ENABLE && !RW && d_ok;
        fe = acc && F;
        err_n = acc && ((ENABLE && !d_ok) || (F && !f_ok));
    end

    always_ff @(posedge CLK) begin
        if (BUSY) begin
            mem[cnt] <= INIT_VAL;
        end else if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (BE[i]) begin
                    mem[da][8*i +: 8] <= DIN[8*i +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write lands
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DOUT <= '0;
            FETCH <= '0;
            DVALID <= 1'b0;
            FVALID <= 1'b0;
            ERR <= 1'b0;
        end else begin
            DVALID <= rd;
            FVALID <= fe;
            ERR <= err_n;
            if (rd) begin
                DOUT <= d_ok ? mem[da] : '0;
            end
            if (fe) begin
                FETCH <= f_ok ? mem[fa] : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Randomised bench for ram_dp_param: two depths share one stimulus
// stream and are compared against a word-level reference model.
module tb_ram_dp_param;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic        RW;
    logic [31:0] ADDR;
    logic [31:0] DIN;
    logic [3:0]  BE;
    logic        F;
    logic [31:0] FADDR;
    logic        CLEAR;

    logic [31:0] dout [2];
    logic [31:0] fetch [2];
    logic        dvalid [2];
    logic        fvalid [2];
    logic        busy [2];
    logic        err [2];

    ram_dp_param #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .INIT_VAL(32'h0)
    ) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .RW(RW),
        .ADDR(ADDR), .DIN(DIN), .BE(BE), .DOUT(dout[0]),
        .DVALID(dvalid[0]), .F(F), .FADDR(FADDR), .FETCH(fetch[0]),
        .FVALID(fvalid[0]), .CLEAR(CLEAR), .BUSY(busy[0]), .ERR(err[0])
    );

    ram_dp_param #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(200), .INIT_VAL(32'h5A5AC3C3)
    ) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .RW(RW),
        .ADDR(ADDR), .DIN(DIN), .BE(BE), .DOUT(dout[1]),
        .DVALID(dvalid[1]), .F(F), .FADDR(FADDR), .FETCH(fetch[1]),
        .FVALID(fvalid[1]), .CLEAR(CLEAR), .BUSY(busy[1]), .ERR(err[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;

    int          dep [2] = '{256, 200};
    logic [31:0] ini [2] = '{32'h0, 32'h5A5AC3C3};
    logic [31:0] mm [2][256];
    int          rem [2];
    logic [31:0] edout [2];
    logic [31:0] efetch [2];
    logic        edv [2];
    logic        efv [2];
    logic        eerr [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Clear is modelled as instant fill plus a busy countdown
    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 256; w++) mm[k][w] = ini[k];
            rem[k] = dep[k];
            edout[k] = '0;
            efetch[k] = '0;
            edv[k] = 1'b0;
            efv[k] = 1'b0;
            eerr[k] = 1'b0;
        end
    endtask

    task automatic step(input int k);
        logic dok, fok;
        edv[k] = 1'b0;
        efv[k] = 1'b0;
        eerr[k] = 1'b0;
        if (rem[k] > 0) begin
            rem[k]--;
        end else if (CLEAR) begin
            for (int w = 0; w < 256; w++) mm[k][w] = ini[k];
            rem[k] = dep[k];
        end else begin
            dok = ADDR < 32'(dep[k]);
            fok = FADDR < 32'(dep[k]);
            if (ENABLE && RW) begin
                edv[k] = 1'b1;
                edout[k] = dok ? mm[k][ADDR] : 32'h0;
            end
            if (F) begin
                efv[k] = 1'b1;
                efetch[k] = fok ? mm[k][FADDR] : 32'h0;
            end
            eerr[k] = (ENABLE && !dok) || (F && !fok);
            if (ENABLE && !RW && dok) begin
                for (int b = 0; b < 4; b++)
                    if (BE[b]) mm[k][ADDR][8*b +: 8] = DIN[8*b +: 8];
            end
        end
    endtask

    task automatic chk_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy%0d", k), 32'(busy[k]), 32'(rem[k] > 0));
            check($sformatf("dvalid%0d", k), 32'(dvalid[k]), 32'(edv[k]));
            check($sformatf("fvalid%0d", k), 32'(fvalid[k]), 32'(efv[k]));
            check($sformatf("err%0d", k), 32'(err[k]), 32'(eerr[k]));
            check($sformatf("dout%0d", k), dout[k], edout[k]);
            check($sformatf("fetch%0d", k), fetch[k], efetch[k]);
        end
    endtask

    task automatic cyc(input logic en, input logic rw, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic f, input logic [31:0] fa,
                       input logic clr);
        ENABLE = en;
        RW = rw;
        ADDR = a;
        DIN = d;
        BE = be;
        F = f;
        FADDR = fa;
        CLEAR = clr;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) step(k);
        #1;
        chk_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hit_reset();
        RESET_N = 1'b0;
        mreset();
        #2;
        chk_all();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk_all();
        RESET_N = 1'b1;
    endtask

    int nb0, nb1;

    initial begin
        ENABLE = 0; RW = 0; ADDR = 0; DIN = 0; BE = 0;
        F = 0; FADDR = 0; CLEAR = 0;
        RESET_N = 1'b0;
        mreset();
        #1;
        chk_all();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        nb0 = 0;
        nb1 = 0;
        for (int i = 0; i < 260; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            if (busy[0]) nb0++;
            if (busy[1]) nb1++;
        end
        // Sampled after each edge, so the last busy edge is not counted
        check("busy_len0", 32'(nb0), 32'd255);
        check("busy_len1", 32'(nb1), 32'd199);

        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 128, 0, 0, 0, 0, 0);
        cyc(1, 1, 255, 0, 0, 0, 0, 0);
        check("rd255_err1", 32'(err[1]), 32'd1);
        idle(1);

        for (int i = 0; i < 8; i++)
            cyc(1, 0, i, 32'hAAAAAAA1 + i, 4'hF, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(1, 1, i, 0, 0, 1, 7 - i, 0);
        idle(1);

        cyc(1, 0, 3, 32'h12345678, 4'b0101, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 0, 0, 0);
        check("be_merge", dout[0], 32'hAA34AA78);

        cyc(1, 0, 5, 32'hDEADBEEF, 4'hF, 1, 5, 0);
        check("rbw_old", fetch[0], 32'hAAAAAAA6);
        cyc(0, 0, 0, 0, 0, 1, 5, 0);
        check("rbw_new", fetch[0], 32'hDEADBEEF);

        cyc(1, 0, 200, 32'h11111111, 4'hF, 0, 0, 0);
        cyc(1, 1, 200, 0, 0, 1, 300, 0);
        check("oor_dout1", dout[1], 32'h0);
        cyc(1, 1, 199, 0, 0, 0, 0, 0);
        check("oor_199", dout[1], 32'h5A5AC3C3);
        idle(1);

        for (int i = 0; i < 2500; i++) begin
            logic [31:0] a, fa;
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(190, 300)
                                            : $urandom_range(0, 15);
            fa = ($urandom_range(0, 9) == 0) ? $urandom_range(190, 300)
                                             : $urandom_range(0, 15);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                $urandom, 4'($urandom), $urandom_range(0, 1) == 1, fa,
                $urandom_range(0, 399) == 0);
        end

        idle(300);
        cyc(1, 0, 1, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
        idle(99);
        check("clr_busy", 32'(busy[0]), 32'd1);
        hit_reset();
        idle(300);
        for (int i = 0; i < 256; i++)
            cyc(1, 1, i, 0, 0, 1, 255 - i, 0);
        idle(2);

        hit_reset();
        idle(20);
        hit_reset();
        idle(260);
        cyc(1, 1, 1, 0, 0, 1, 199, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
